alu_cmd_ctrl: RTL

ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

---
 rtl/alu_cmd_ctrl_if.sv | 30 +++
 rtl/alu_cmd_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/alu_cmd_ctrl_if.sv
// Byte-stream command, ALU and transmitter signals of the ALU command controller.
// The master side is the environment; the slave side is the controller itself.
interface alu_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 2 * DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] RX_P_DATA;
  logic                  RX_D_VLD;
  logic [OUT_WIDTH-1:0]  ALU_OUT;
  logic                  ALU_OUT_VLD;
  logic                  TX_BUSY;
  logic [DATA_WIDTH-1:0] OP_A;
  logic [DATA_WIDTH-1:0] OP_B;
  logic [3:0]            ALU_FUN;
  logic                  ALU_EN;
  logic                  CLK_GATE_EN;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_D_VLD;
  logic                  CMD_ERR;

  modport master (
    output RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    input  OP_A, OP_B, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD, CMD_ERR
  );

  modport slave (
    input  RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    output OP_A, OP_B, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD, CMD_ERR
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Decodes 0xCC (A, B, FUN) and 0xDD (FUN) byte commands, runs one ALU operation
// with a bounded wait for its result, and sends the result low byte then high byte.
module alu_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 2 * DATA_WIDTH,
  parameter int TMO_CYC    = 15
) (
  input logic          CLK,
  input logic          RST,
  alu_cmd_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0]      TMO_LAST = CNT_W'(TMO_CYC - 1);
  localparam logic [DATA_WIDTH-1:0] CMD_FULL = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_REUSE = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, WAIT_RES, SEND_LO, SEND_HI
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [DATA_WIDTH-1:0] r_opA;
  logic [DATA_WIDTH-1:0] r_opB;
  logic [3:0]            r_aluFun;
  logic [OUT_WIDTH-1:0]  r_result;
  logic [CNT_W-1:0]      r_tmoCnt;
  logic                  r_cmdErr;
  logic                  w_capA;
  logic                  w_capB;
  logic                  w_capFun;
  logic                  w_latchRes;
  logic                  w_cmdErr;
  logic [DATA_WIDTH-1:0] w_txData;

  always_ff @(posedge CLK) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  // Operands and function persist across commands so 0xDD can reuse them.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_opA    <= '0;
      r_opB    <= '0;
      r_aluFun <= '0;
      r_result <= '0;
      r_tmoCnt <= '0;
      r_cmdErr <= 1'b0;
    end else begin
      if (w_capA)     r_opA    <= bus.RX_P_DATA;
      if (w_capB)     r_opB    <= bus.RX_P_DATA;
      if (w_capFun)   r_aluFun <= bus.RX_P_DATA[3:0];
      if (w_latchRes) r_result <= bus.ALU_OUT;
      r_tmoCnt <= (r_state == WAIT_RES) ? r_tmoCnt + CNT_W'(1) : '0;
      r_cmdErr <= w_cmdErr;
    end
  end

  // A byte arriving while busy is dropped without disturbing the ALU/TX flow.
  always_comb begin
    w_nextState = r_state;
    w_capA      = 1'b0;
    w_capB      = 1'b0;
    w_capFun    = 1'b0;
    w_latchRes  = 1'b0;
    w_cmdErr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.RX_D_VLD) begin
          if (bus.RX_P_DATA == CMD_FULL)       w_nextState = GET_A;
          else if (bus.RX_P_DATA == CMD_REUSE) w_nextState = GET_FUN;
          else                                 w_cmdErr    = 1'b1;
        end
      end
      GET_A: begin
        if (bus.RX_D_VLD) begin
          w_capA      = 1'b1;
          w_nextState = GET_B;
        end
      end
      GET_B: begin
        if (bus.RX_D_VLD) begin
          w_capB      = 1'b1;
          w_nextState = GET_FUN;
        end
      end
      GET_FUN: begin
        if (bus.RX_D_VLD) begin
          w_capFun    = 1'b1;
          w_nextState = ALU_RUN;
        end
      end
      ALU_RUN: begin
        w_cmdErr    = bus.RX_D_VLD;
        w_nextState = WAIT_RES;
      end
      WAIT_RES: begin
        w_cmdErr = bus.RX_D_VLD;
        if (bus.ALU_OUT_VLD) begin
          w_latchRes  = 1'b1;
          w_nextState = SEND_LO;
        end else if (r_tmoCnt == TMO_LAST) begin
          w_cmdErr    = 1'b1;
          w_nextState = IDLE;
        end
      end
      SEND_LO: begin
        w_cmdErr = bus.RX_D_VLD;
        if (!bus.TX_BUSY) w_nextState = SEND_HI;
      end
      SEND_HI: begin
        w_cmdErr = bus.RX_D_VLD;
        if (!bus.TX_BUSY) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_txData = '0;
    if (r_state == SEND_LO)      w_txData = r_result[DATA_WIDTH-1:0];
    else if (r_state == SEND_HI) w_txData = r_result[DATA_WIDTH +: DATA_WIDTH];
  end

  assign bus.OP_A        = r_opA;
  assign bus.OP_B        = r_opB;
  assign bus.ALU_FUN     = r_aluFun;
  assign bus.ALU_EN      = (r_state == ALU_RUN);
  assign bus.CLK_GATE_EN = (r_state == ALU_RUN) || (r_state == WAIT_RES);
  assign bus.TX_D_VLD    = (r_state == SEND_LO) || (r_state == SEND_HI);
  assign bus.TX_P_DATA   = w_txData;
  assign bus.CMD_ERR     = r_cmdErr;

endmodule
